// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: access sizes, FSM states
// and the alignment check applied when a request is accepted.
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_ADDR = 3'd1,
    ST_RD_CAP  = 3'd2,
    ST_WR      = 3'd3,
    ST_RESP    = 3'd4
  } lsu_state_e;

  function automatic logic is_misaligned(input size_e size, input logic [1:0] lo);
    logic mis;
    case (size)
      SZ_HALF: mis = lo[0];
      SZ_WORD: mis = (lo != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte/halfword lane handling: load extraction with sign/zero extension and
// store merging of sub-word data into a previously read word.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lo,
  input  size_e       size,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_data
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Lane selection, extension and merge
  always_comb begin
    byte_s     = 8'h00;
    half_s     = 16'h0000;
    load_data  = 32'h0000_0000;
    store_data = word;

    case (lo)
      2'b00:   byte_s = word[7:0];
      2'b01:   byte_s = word[15:8];
      2'b10:   byte_s = word[23:16];
      2'b11:   byte_s = word[31:24];
      default: byte_s = 8'h00;
    endcase

    if (lo[1]) begin
      half_s = word[31:16];
    end else begin
      half_s = word[15:0];
    end

    case (size)
      SZ_BYTE: load_data = {{24{byte_s[7] & ~is_unsigned}}, byte_s};
      SZ_HALF: load_data = {{16{half_s[15] & ~is_unsigned}}, half_s};
      SZ_WORD: load_data = word;
      default: load_data = 32'h0000_0000;
    endcase

    case (size)
      SZ_BYTE: begin
        case (lo)
          2'b00:   store_data[7:0]   = wdata[7:0];
          2'b01:   store_data[15:8]  = wdata[7:0];
          2'b10:   store_data[23:16] = wdata[7:0];
          2'b11:   store_data[31:24] = wdata[7:0];
          default: store_data        = word;
        endcase
      end
      SZ_HALF: begin
        if (lo[1]) begin
          store_data[31:16] = wdata[15:0];
        end else begin
          store_data[15:0] = wdata[15:0];
        end
      end
      SZ_WORD: store_data = wdata;
      default: store_data = word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit in front of a word-only data memory. Sub-word stores run as
// read-modify-write; misaligned or reserved-size requests respond with err.
module load_store_unit
  import lsu_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_we,
  input  logic [1:0]  i_req_size,
  input  logic        i_req_unsigned,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_err,
  output logic [31:0] o_mem_A,
  output logic [31:0] o_mem_WD,
  output logic        o_mem_WE,
  input  logic [31:0] i_mem_RD
);

  lsu_state_e  state_r;
  logic [31:0] addr_r;
  size_e       size_r;
  logic        we_r;
  logic        uns_r;
  logic [31:0] wdata_r;

  size_e       req_size_s;
  logic        req_err_s;
  logic [31:0] load_data_s;
  logic [31:0] store_data_s;

  assign req_size_s  = size_e'(i_req_size);
  assign req_err_s   = (req_size_s == SZ_RSVD) || is_misaligned(req_size_s, i_req_addr[1:0]);
  assign o_req_ready = (state_r == ST_IDLE);

  // Lane logic works straight off the memory read data during RD_CAP
  lsu_lane_align u_lane_align (
    .word        (i_mem_RD),
    .lo          (addr_r[1:0]),
    .size        (size_r),
    .is_unsigned (uns_r),
    .wdata       (wdata_r),
    .load_data   (load_data_s),
    .store_data  (store_data_s)
  );

  // Request FSM with registered memory and response outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r     <= ST_IDLE;
      addr_r      <= 32'h0000_0000;
      size_r      <= SZ_BYTE;
      we_r        <= 1'b0;
      uns_r       <= 1'b0;
      wdata_r     <= 32'h0000_0000;
      o_rsp_valid <= 1'b0;
      o_rsp_rdata <= 32'h0000_0000;
      o_rsp_err   <= 1'b0;
      o_mem_A     <= 32'h0000_0000;
      o_mem_WD    <= 32'h0000_0000;
      o_mem_WE    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (i_req_valid) begin
            addr_r  <= i_req_addr;
            size_r  <= req_size_s;
            we_r    <= i_req_we;
            uns_r   <= i_req_unsigned;
            wdata_r <= i_req_wdata;
            if (req_err_s) begin
              o_rsp_valid <= 1'b1;
              o_rsp_rdata <= 32'h0000_0000;
              o_rsp_err   <= 1'b1;
              state_r     <= ST_RESP;
            end else begin
              o_mem_A <= {i_req_addr[31:2], 2'b00};
              if (i_req_we && (req_size_s == SZ_WORD)) begin
                o_mem_WD <= i_req_wdata;
                o_mem_WE <= 1'b1;
                state_r  <= ST_WR;
              end else begin
                state_r  <= ST_RD_ADDR;
              end
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_RD_ADDR: begin
          state_r <= ST_RD_CAP;
        end
        ST_RD_CAP: begin
          if (we_r) begin
            o_mem_A  <= {addr_r[31:2], 2'b00};
            o_mem_WD <= store_data_s;
            o_mem_WE <= 1'b1;
            state_r  <= ST_WR;
          end else begin
            o_rsp_valid <= 1'b1;
            o_rsp_rdata <= load_data_s;
            o_rsp_err   <= 1'b0;
            state_r     <= ST_RESP;
          end
        end
        ST_WR: begin
          o_mem_WE    <= 1'b0;
          o_rsp_valid <= 1'b1;
          o_rsp_rdata <= 32'h0000_0000;
          o_rsp_err   <= 1'b0;
          state_r     <= ST_RESP;
        end
        ST_RESP: begin
          if (i_rsp_ready) begin
            o_rsp_valid <= 1'b0;
            state_r     <= ST_IDLE;
          end else begin
            state_r <= ST_RESP;
          end
        end
        default: begin
          o_mem_WE    <= 1'b0;
          o_rsp_valid <= 1'b0;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural word memory model.
module tb_load_store_unit;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_req_valid = 1'b0;
  logic        o_req_ready;
  logic        i_req_we = 1'b0;
  logic [1:0]  i_req_size = 2'b00;
  logic        i_req_unsigned = 1'b0;
  logic [31:0] i_req_addr = 32'h0;
  logic [31:0] i_req_wdata = 32'h0;
  logic        o_rsp_valid;
  logic        i_rsp_ready = 1'b1;
  logic [31:0] o_rsp_rdata;
  logic        o_rsp_err;
  logic [31:0] o_mem_A;
  logic [31:0] o_mem_WD;
  logic        o_mem_WE;
  logic [31:0] i_mem_RD;

  logic [31:0] mem [0:255];
  logic [31:0] rd_q = 32'h0;
  int          we_cnt = 0;
  logic [31:0] we_a = 32'h0;
  logic [31:0] we_wd = 32'h0;
  int          n_vec = 0;
  int          n_err = 0;

  load_store_unit dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_we(i_req_we), .i_req_size(i_req_size), .i_req_unsigned(i_req_unsigned),
    .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata), .o_rsp_valid(o_rsp_valid),
    .i_rsp_ready(i_rsp_ready), .o_rsp_rdata(o_rsp_rdata), .o_rsp_err(o_rsp_err),
    .o_mem_A(o_mem_A), .o_mem_WD(o_mem_WD), .o_mem_WE(o_mem_WE), .i_mem_RD(i_mem_RD)
  );

  always #5 i_clk = ~i_clk;

  assign i_mem_RD = rd_q;

  always @(posedge i_clk) begin
    if (o_mem_WE === 1'b1) begin
      mem[o_mem_A[9:2]] <= o_mem_WD;
      we_cnt <= we_cnt + 1;
      we_a   <= o_mem_A;
      we_wd  <= o_mem_WD;
    end
    rd_q <= mem[o_mem_A[9:2]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic txn(input logic we, input logic [1:0] size, input logic uns,
                     input logic [31:0] addr, input logic [31:0] wdata, input int hold,
                     output int lat, output logic [31:0] rdata, output logic err,
                     output int wed);
    int we0;
    we0 = we_cnt;
    @(negedge i_clk);
    i_req_valid = 1'b1; i_req_we = we; i_req_size = size; i_req_unsigned = uns;
    i_req_addr = addr; i_req_wdata = wdata; i_rsp_ready = (hold == 0);
    @(posedge i_clk);
    #1 i_req_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge i_clk);
      lat++;
    end while (o_rsp_valid !== 1'b1 && lat < 20);
    rdata = o_rsp_rdata;
    err   = o_rsp_err;
    if (hold > 0) begin
      for (int k = 0; k < hold; k++) begin
        @(negedge i_clk);
        chk("bp_valid", {31'h0, o_rsp_valid}, 32'h1);
        chk("bp_rdata", o_rsp_rdata, rdata);
        chk("bp_ready", {31'h0, o_req_ready}, 32'h0);
      end
      i_rsp_ready = 1'b1;
    end
    @(posedge i_clk);
    #1 wed = we_cnt - we0;
  endtask

  initial begin
    int lat;
    int wed;
    int we_snap;
    logic [31:0] rdata;
    logic err;

    for (int i = 0; i < 256; i++) mem[i] = 32'h0;

    #12;
    chk("rst_rsp_valid", {31'h0, o_rsp_valid}, 32'h0);
    chk("rst_rdata", o_rsp_rdata, 32'h0);
    chk("rst_mem_A", o_mem_A, 32'h0);
    chk("rst_mem_WE", {31'h0, o_mem_WE}, 32'h0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    chk("idle_ready", {31'h0, o_req_ready}, 32'h1);

    // Word store then word load
    txn(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF, 0, lat, rdata, err, wed);
    chk("sw_lat", 32'(lat), 32'd2);
    chk("sw_we_pulses", 32'(wed), 32'd1);
    chk("sw_we_addr", we_a, 32'h100);
    chk("sw_we_data", we_wd, 32'hDEADBEEF);
    txn(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 0, lat, rdata, err, wed);
    chk("lw_lat", 32'(lat), 32'd3);
    chk("lw_rdata", rdata, 32'hDEADBEEF);
    chk("lw_err", {31'h0, err}, 32'h0);
    chk("lw_no_we", 32'(wed), 32'd0);

    // Sign/zero-extended sub-word loads
    txn(1'b1, 2'b10, 1'b0, 32'h100, 32'h80FF7F01, 0, lat, rdata, err, wed);
    txn(1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 0, lat, rdata, err, wed);
    chk("lb_103", rdata, 32'hFFFFFF80);
    txn(1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 0, lat, rdata, err, wed);
    chk("lbu_103", rdata, 32'h00000080);
    txn(1'b0, 2'b00, 1'b0, 32'h101, 32'h0, 0, lat, rdata, err, wed);
    chk("lb_101", rdata, 32'h0000007F);
    txn(1'b0, 2'b01, 1'b0, 32'h102, 32'h0, 0, lat, rdata, err, wed);
    chk("lh_102", rdata, 32'hFFFF80FF);
    txn(1'b0, 2'b01, 1'b1, 32'h100, 32'h0, 0, lat, rdata, err, wed);
    chk("lhu_100", rdata, 32'h00007F01);

    // Read-modify-write sub-word stores
    txn(1'b1, 2'b10, 1'b0, 32'h200, 32'h11223344, 0, lat, rdata, err, wed);
    txn(1'b1, 2'b00, 1'b0, 32'h201, 32'h000000AA, 0, lat, rdata, err, wed);
    chk("sb_lat", 32'(lat), 32'd4);
    chk("sb_we_pulses", 32'(wed), 32'd1);
    chk("sb_we_data", we_wd, 32'h1122AA44);
    chk("sb_rdata", rdata, 32'h0);
    txn(1'b1, 2'b01, 1'b0, 32'h202, 32'h0000BEEF, 0, lat, rdata, err, wed);
    chk("sh_lat", 32'(lat), 32'd4);
    chk("sh_we_addr", we_a, 32'h200);
    chk("sh_mem", mem[8'h80], 32'hBEEFAA44);

    // Misaligned and reserved-size requests
    txn(1'b0, 2'b10, 1'b0, 32'h102, 32'h0, 0, lat, rdata, err, wed);
    chk("lw_mis_err", {31'h0, err}, 32'h1);
    chk("lw_mis_rdata", rdata, 32'h0);
    chk("lw_mis_lat", 32'(lat), 32'd1);
    txn(1'b1, 2'b01, 1'b0, 32'h101, 32'h0000FFFF, 0, lat, rdata, err, wed);
    chk("sh_mis_err", {31'h0, err}, 32'h1);
    chk("sh_mis_lat", 32'(lat), 32'd1);
    chk("sh_mis_no_we", 32'(wed), 32'd0);
    txn(1'b1, 2'b11, 1'b0, 32'h100, 32'h12345678, 0, lat, rdata, err, wed);
    chk("rsvd_err", {31'h0, err}, 32'h1);
    chk("rsvd_no_we", 32'(wed), 32'd0);
    chk("rsvd_mem_intact", mem[8'h40], 32'h80FF7F01);

    // Backpressure on a load
    txn(1'b0, 2'b10, 1'b0, 32'h200, 32'h0, 5, lat, rdata, err, wed);
    chk("bp_lat", 32'(lat), 32'd3);
    chk("bp_data", rdata, 32'hBEEFAA44);
    chk("bp_after_valid", {31'h0, o_rsp_valid}, 32'h0);
    chk("bp_after_ready", {31'h0, o_req_ready}, 32'h1);

    // Top-of-memory aligned address
    txn(1'b1, 2'b10, 1'b0, 32'hFFFFFFFC, 32'h12345678, 0, lat, rdata, err, wed);
    chk("wrap_err", {31'h0, err}, 32'h0);
    chk("wrap_we_addr", we_a, 32'hFFFFFFFC);
    txn(1'b0, 2'b10, 1'b0, 32'hFFFFFFFC, 32'h0, 0, lat, rdata, err, wed);
    chk("wrap_load", rdata, 32'h12345678);

    // Reset during RD_CAP of a byte store
    txn(1'b1, 2'b10, 1'b0, 32'h300, 32'hCAFEF00D, 0, lat, rdata, err, wed);
    we_snap = we_cnt;
    @(negedge i_clk);
    i_req_valid = 1'b1; i_req_we = 1'b1; i_req_size = 2'b00; i_req_unsigned = 1'b0;
    i_req_addr = 32'h300; i_req_wdata = 32'h00000055;
    @(posedge i_clk);
    #1 i_req_valid = 1'b0;
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b0;
    #1;
    chk("mrst_rsp_valid", {31'h0, o_rsp_valid}, 32'h0);
    chk("mrst_mem_A", o_mem_A, 32'h0);
    chk("mrst_mem_WD", o_mem_WD, 32'h0);
    chk("mrst_mem_WE", {31'h0, o_mem_WE}, 32'h0);
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
    repeat (4) @(negedge i_clk);
    chk("mrst_no_we", 32'(we_cnt - we_snap), 32'd0);
    chk("mrst_ready", {31'h0, o_req_ready}, 32'h1);
    txn(1'b0, 2'b10, 1'b0, 32'h300, 32'h0, 0, lat, rdata, err, wed);
    chk("mrst_mem_intact", rdata, 32'hCAFEF00D);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits directly upstream of data_mem, between the execute stage and the data memory.
- Accepts one load/store request at a time over a valid/ready handshake and performs the word-aligned memory access.
- Loads: extracts the byte or halfword lane and sign- or zero-extends it.
- Sub-word stores: data_mem only writes full words, so these run as read-modify-write sequences.
- Misaligned or illegal requests are flagged without touching memory.

Parameters:
- None. The address and data widths are fixed at 32 to match data_mem.

Ports:
- i_clk  in  1  core clock
- i_rst_n  in  1  reset, active-low
- i_req_valid  in  1  request present
- o_req_ready  out  1  block idle, can accept a request
- i_req_we  in  1  1 = store, 0 = load
- i_req_size  in  2  00 byte, 01 half, 10 word, 11 reserved
- i_req_unsigned  in  1  load zero-extends (lbu/lhu); ignored for stores
- i_req_addr  in  32  byte address
- i_req_wdata  in  32  store data, right-justified
- o_rsp_valid  out  1  response present
- i_rsp_ready  in  1  consumer takes the response
- o_rsp_rdata  out  32  extended load data; 0 for stores and errors
- o_rsp_err  out  1  misaligned or reserved-size request
- o_mem_A  out  32  data_mem address, always word-aligned (bits [1:0] = 0)
- o_mem_WD  out  32  data_mem write data
- o_mem_WE  out  1  data_mem write enable
- i_mem_RD  in  32  data_mem read data

Behaviour:
- One clock, i_clk. Reset is asynchronous and active-low on i_rst_n.
- Reset values:
  - state = IDLE
  - o_rsp_valid = 0, o_rsp_rdata = 0, o_rsp_err = 0
  - o_mem_A = 0, o_mem_WD = 0, o_mem_WE = 0
  - all latched request fields = 0
- Reset mid-operation aborts immediately. No write is issued after reset deasserts. A pending response is discarded.
- Memory model:
  - data_mem samples A on the edge; RD is valid in the following cycle whenever WE = 0.
  - When WE = 1, data_mem writes bytes A..A+3 little-endian on the edge.
- o_req_ready = (state == IDLE). A request is accepted on a cycle with i_req_valid && o_req_ready. All request fields are latched on that edge.
- Error check at acceptance. The request is an error if any of:
  - size = 11
  - half with addr[0] = 1
  - word with addr[1:0] != 0
- An erroring request goes straight to RESP with err = 1, rdata = 0, and never asserts o_mem_WE.
- States:
  - IDLE
  - RD_ADDR: drive o_mem_A = {addr[31:2], 2'b00}, WE = 0
  - RD_CAP: capture i_mem_RD into the word register
  - WR: drive A and WD, WE = 1 for exactly one cycle
  - RESP
- Transitions:
  - load: IDLE -> RD_ADDR -> RD_CAP -> RESP
  - word store: IDLE -> WR (WD = wdata) -> RESP
  - byte/half store: IDLE -> RD_ADDR -> RD_CAP (merge) -> WR -> RESP
  - error: IDLE -> RESP
- Latency from the accept edge to o_rsp_valid high: load 3 cycles, word store 2, sub-word store 4, error 1.
- Load extraction:
  - byte: lane addr[1:0] (lane 0 = bits 7:0)
  - half: lane addr[1]
  - bit 7 (byte) or bit 15 (half) replicated unless unsigned
  - word passes through unchanged
- Store merge:
  - byte: read word with lane addr[1:0] replaced by wdata[7:0]
  - half: read word with lane addr[1] replaced by wdata[15:0]
  - other bytes are preserved
- RESP: o_rsp_valid is held, with rdata/err stable, until i_rsp_ready. On the handshake edge the block returns to IDLE. Back-to-back requests are not overlapped, so a new request is accepted no earlier than the cycle after the response handshake.
- o_mem_WE is 1 only in WR. In all other states o_mem_A holds the last aligned address and WD holds its last value.
- Address wrap: aligned address 0xFFFFFFFC is legal; no carry is generated.

Decomposition:
- Package lsu_pkg holds:
  - typedef enum size_e {SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10, SZ_RSVD = 2'b11}
  - lsu_state_e
  - function is_misaligned(size, addr[1:0])
- Sub-module lsu_lane_align, purely combinational:
  - load_extract(word, addr[1:0], size, unsigned) -> 32 bits
  - store_merge(old_word, wdata, addr[1:0], size) -> 32 bits
- The top level holds the FSM and registers.

Test Plan:
- Word store then load: store addr 0x100, data 0xDEADBEEF, then load word 0x100 -> WE high exactly one cycle with A = 0x100; load rsp after 3 cycles, rdata = 0xDEADBEEF, err = 0.
- Signed/unsigned byte loads: memory word at 0x100 = 0x80FF7F01. lb 0x103 -> 0xFFFFFF80; lbu 0x103 -> 0x00000080; lb 0x101 -> 0x0000007F; lh 0x102 -> 0xFFFF80FF.
- Sub-word RMW: word at 0x200 = 0x11223344. sb 0x201 with 0xAA -> memory becomes 0x1122AA44. sh 0x202 with 0xBEEF -> memory becomes 0xBEEFAA44. Response arrives 4 cycles after accept.
- Misalignment: lw 0x102, sh 0x101, size 11 -> err = 1, rdata = 0, response 1 cycle after accept, o_mem_WE never asserted.
- Backpressure: hold i_rsp_ready = 0 for 5 cycles on a load -> o_rsp_valid and rdata stable, o_req_ready = 0 throughout; the next request is accepted only after the handshake.
- Reset mid-RMW: assert i_rst_n low during RD_CAP of sb 0x300 -> all outputs 0 immediately, o_mem_WE stays 0 after release, memory at 0x300 unchanged.
